// File: rtl/gates_pkg.sv
// Shared op encoding for the gate ALU pipeline.
package gates_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NOT  = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   // Op 7 becomes an accumulate-XOR when GATES_ACC_EN is defined.
   localparam logic [OP_W-1:0] OP_ACC_XOR = 3'd7;

endpackage

// File: rtl/gates_op_comb.sv
// Combinational gate operation: (a, b, op[, acc]) -> result_c.
// With GATES_ACC_EN defined, op 7 yields acc ^ a instead of passing a through.
module gates_op_comb
   import gates_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
`ifdef GATES_ACC_EN
   input  logic [WIDTH-1:0] acc,
`endif
   output logic [WIDTH-1:0] result_c
);

   // Select the bitwise function for the current op.
   always_comb begin
      result_c = '0;
      case (op)
         OP_AND:  result_c = a & b;
         OP_OR:   result_c = a | b;
         OP_XOR:  result_c = a ^ b;
         OP_NOT:  result_c = ~a;
         OP_NAND: result_c = ~(a & b);
         OP_NOR:  result_c = ~(a | b);
         OP_XNOR: result_c = ~(a ^ b);
`ifdef GATES_ACC_EN
         OP_ACC_XOR: result_c = acc ^ a;
`else
         OP_PASS: result_c = a;
`endif
         default: result_c = '0;
      endcase
   end

endmodule

// File: rtl/gates_alu_pipe.sv
// Registered gate ALU with valid/ready on both sides, result flags and a
// saturating accepted-op counter. Optional macro: GATES_ACC_EN turns op 7
// into ACC_XOR against an internal accumulator.
module gates_alu_pipe
   import gates_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ones,
   output logic [CNT_W-1:0] op_count
);

   logic             accept_c;
   logic             drain_c;
   logic [WIDTH-1:0] result_c;

`ifdef GATES_ACC_EN
   logic [WIDTH-1:0] acc;
`endif

   // Output slot is free when empty or being drained this cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept_c = in_valid && in_ready;
   assign drain_c  = out_valid && out_ready;

   gates_op_comb #(
      .WIDTH (WIDTH)
   ) u_op (
      .a        (a),
      .b        (b),
      .op       (op),
`ifdef GATES_ACC_EN
      .acc      (acc),
`endif
      .result_c (result_c)
   );

   // Output register: load on accept, clear valid on drain-only, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         zero      <= 1'b0;
         ones      <= 1'b0;
      end else if (accept_c) begin
         out_valid <= 1'b1;
         y         <= result_c;
         zero      <= (result_c == '0);
         ones      <= (result_c == '1);
      end else if (drain_c) begin
         out_valid <= 1'b0;
      end
   end

   // Accepted-op counter, sticks at all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if (accept_c && (op_count != '1)) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

`ifdef GATES_ACC_EN
   // Accumulator only moves on an accepted ACC_XOR.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (accept_c && (op == OP_ACC_XOR)) begin
         acc <= acc ^ a;
      end
   end
`endif

endmodule

// File: tb/tb_gates_alu_pipe.sv
// Directed bench for gates_alu_pipe; expectations follow GATES_ACC_EN.
module tb_gates_alu_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;

   logic        in_ready, out_valid, zero, ones;
   logic [7:0]  y;
   logic [15:0] op_count;

   logic        s_in_ready, s_out_valid, s_zero, s_ones;
   logic [7:0]  s_y;
   logic [1:0]  s_op_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gates_alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero(zero), .ones(ones), .op_count(op_count)
   );

   // Narrow counter instance sharing the same stimulus, for saturation.
   gates_alu_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .a(a), .b(b), .op(op), .out_valid(s_out_valid), .out_ready(out_ready),
      .y(s_y), .zero(s_zero), .ones(s_ones), .op_count(s_op_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] op_y   [7];
   logic       op_z   [7];
   logic       op_o   [7];
   logic [7:0] x_a    [4];
   logic [7:0] x_b    [4];
   logic [7:0] x_y    [4];
   logic [7:0] acc_a  [3];
   logic [7:0] acc_y  [3];

   initial begin
      op_y = '{8'h00, 8'hFF, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'h00};
      op_z = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
      op_o = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
      x_a  = '{8'h12, 8'hFF, 8'hAA, 8'h5A};
      x_b  = '{8'h34, 8'h0F, 8'h55, 8'h5A};
      x_y  = '{8'h26, 8'hF0, 8'hFF, 8'h00};
      acc_a = '{8'h0F, 8'hF0, 8'hFF};
`ifdef GATES_ACC_EN
      acc_y = '{8'h0F, 8'hFF, 8'h00};
`else
      acc_y = '{8'h0F, 8'hF0, 8'hFF};
`endif

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = 8'h00; b = 8'h00; op = 3'd0;
      tick(); tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y", 32'(y), 32'h00);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_ones", 32'(ones), 32'd0);
      check("rst_count", 32'(op_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Each basic op at full throughput.
      a = 8'hC5; b = 8'h3A; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         op = 3'(i);
         tick();
         check($sformatf("op%0d_y", i), 32'(y), 32'(op_y[i]));
         check($sformatf("op%0d_zero", i), 32'(zero), 32'(op_z[i]));
         check($sformatf("op%0d_ones", i), 32'(ones), 32'(op_o[i]));
         check($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("op%0d_count", i), 32'(op_count), 32'(i + 1));
         check($sformatf("op%0d_sat", i), 32'(s_op_count), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      in_valid = 1'b0;
      tick();
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_y_hold", 32'(y), 32'h00);
      check("drain_zero_hold", 32'(zero), 32'd1);

      // Backpressure holds the result.
      op = 3'd0; a = 8'hFF; b = 8'h0F; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      check("bp_load_y", 32'(y), 32'h0F);
      check("bp_load_count", 32'(op_count), 32'd8);
      for (int i = 0; i < 3; i++) begin
         a = 8'(i * 8'h31); b = 8'hAA;
         check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
         tick();
         check($sformatf("bp%0d_y", i), 32'(y), 32'h0F);
         check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_count", i), 32'(op_count), 32'd8);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("bp_drain_valid", 32'(out_valid), 32'd0);
      check("bp_drain_in_ready", 32'(in_ready), 32'd1);
      check("bp_drain_y", 32'(y), 32'h0F);

      // Back-to-back XOR stream.
      op = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = x_a[i]; b = x_b[i];
         tick();
         check($sformatf("b2b%0d_y", i), 32'(y), 32'(x_y[i]));
         check($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
      end
      check("b2b_zero", 32'(zero), 32'd1);
      check("b2b_count", 32'(op_count), 32'd12);

      // Op 7: PASS or ACC_XOR depending on build.
      op = 3'd7; b = 8'h99;
      for (int i = 0; i < 3; i++) begin
         a = acc_a[i];
         tick();
         check($sformatf("op7_%0d_y", i), 32'(y), 32'(acc_y[i]));
         check($sformatf("op7_%0d_zero", i), 32'(zero), 32'(acc_y[i] == 8'h00));
         check($sformatf("op7_%0d_ones", i), 32'(ones), 32'(acc_y[i] == 8'hFF));
      end
      check("op7_count", 32'(op_count), 32'd15);
      in_valid = 1'b0;
      tick();

      // Reset with a result pending under backpressure.
      op = 3'd1; a = 8'h3C; b = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      check("mid_pending_valid", 32'(out_valid), 32'd1);
      check("mid_pending_y", 32'(y), 32'h3C);
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_y", 32'(y), 32'h00);
      check("mid_rst_count", 32'(op_count), 32'd0);
      check("mid_rst_sat", 32'(s_op_count), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);

      // Op 7 after reset: accumulator, if present, starts from zero.
      op = 3'd7; a = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      check("post_rst_op7_y", 32'(y), 32'h0F);
      check("post_rst_op7_count", 32'(op_count), 32'd1);
      in_valid = 1'b0;
      tick();
      check("final_valid", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
